// File: rtl/gb_io_responder.sv
// ============================================================================
// Module  : gb_io_responder
// Purpose : CPU-side I/O responder owning IF/IE, DIV/TIMA/TMA/TAC and,
//           when GB_IO_HRAM_EN is defined, 127-byte HRAM at 0xFF80-0xFFFE.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gb_io_responder #(
  parameter int          DIV_WIDTH     = 16,
  parameter logic [7:0]  UNMAPPED_READ = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr_i,
  input  logic [7:0]  wdata_i,
  input  logic        wr_i,
  output logic [7:0]  rdata_o,
  output logic        hit_o,
  input  logic [4:0]  irq_i,
  input  logic        clear_interrupt_flag,
  output logic [7:0]  reg_IF,
  output logic [7:0]  reg_IE
);

  localparam logic [15:0] C_ADDR_DIV  = 16'hFF04;
  localparam logic [15:0] C_ADDR_TIMA = 16'hFF05;
  localparam logic [15:0] C_ADDR_TMA  = 16'hFF06;
  localparam logic [15:0] C_ADDR_TAC  = 16'hFF07;
  localparam logic [15:0] C_ADDR_IF   = 16'hFF0F;
  localparam logic [15:0] C_ADDR_IE   = 16'hFFFF;

  logic [DIV_WIDTH-1:0] r_div;
  logic [7:0]           r_tima;
  logic [7:0]           r_tma;
  logic [2:0]           r_tac;
  logic [4:0]           r_if;
  logic [7:0]           r_ie;
  logic                 r_div_bit_q;

  logic w_wr_div, w_wr_tima, w_wr_tma, w_wr_tac, w_wr_if, w_wr_ie;
  logic w_div_bit;
  logic w_tick;
  logic w_overflow;
  logic [4:0] w_hw_set;
  logic [4:0] w_pending;
  logic [4:0] w_clr;
  logic [4:0] w_if_next;
  logic       w_unused;

  // Bit 2 of irq_i is not used; the timer request comes from TIMA overflow.
  assign w_unused = irq_i[2];

  assign w_wr_div  = wr_i && (addr_i == C_ADDR_DIV);
  assign w_wr_tima = wr_i && (addr_i == C_ADDR_TIMA);
  assign w_wr_tma  = wr_i && (addr_i == C_ADDR_TMA);
  assign w_wr_tac  = wr_i && (addr_i == C_ADDR_TAC);
  assign w_wr_if   = wr_i && (addr_i == C_ADDR_IF);
  assign w_wr_ie   = wr_i && (addr_i == C_ADDR_IE);

  always_comb begin
    w_div_bit = r_div[9];
    case (r_tac[1:0])
      2'b00:   w_div_bit = r_div[9];
      2'b01:   w_div_bit = r_div[3];
      2'b10:   w_div_bit = r_div[5];
      default: w_div_bit = r_div[7];
    endcase
  end

  // Falling edge seen against last cycle's copy, so a DIV reset glitch also ticks.
  assign w_tick     = r_tac[2] && r_div_bit_q && !w_div_bit;
  assign w_overflow = w_tick && !w_wr_tima && (r_tima == 8'hFF);

  // Lowest-index pending interrupt is the one acknowledged.
  assign w_pending = r_if & r_ie[4:0];
  assign w_clr     = clear_interrupt_flag ? (w_pending & (~w_pending + 5'd1)) : 5'd0;
  assign w_hw_set  = {irq_i[4], irq_i[3], w_overflow, irq_i[1], irq_i[0]};
  assign w_if_next = w_hw_set | (w_wr_if ? wdata_i[4:0] : (r_if & ~w_clr));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div       <= '0;
      r_div_bit_q <= 1'b0;
    end else begin
      r_div       <= w_wr_div ? '0 : r_div + 1'b1;
      r_div_bit_q <= w_div_bit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tima <= 8'h00;
      r_tma  <= 8'h00;
      r_tac  <= 3'b000;
    end else begin
      if (w_wr_tma) begin
        r_tma <= wdata_i;
      end
      if (w_wr_tac) begin
        r_tac <= wdata_i[2:0];
      end
      if (w_wr_tima) begin
        r_tima <= wdata_i;
      end else if (w_overflow) begin
        r_tima <= w_wr_tma ? wdata_i : r_tma;
      end else if (w_tick) begin
        r_tima <= r_tima + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if <= 5'd0;
      r_ie <= 8'h00;
    end else begin
      r_if <= w_if_next;
      if (w_wr_ie) begin
        r_ie <= wdata_i;
      end
    end
  end

  assign reg_IF = {3'b111, r_if};
  assign reg_IE = r_ie;

`ifdef GB_IO_HRAM_EN
  logic [7:0] r_hram [0:126];
  logic       w_sel_hram;

  assign w_sel_hram = (addr_i[15:7] == 9'h1FF) && (addr_i[6:0] != 7'h7F);

  always_ff @(posedge clk) begin
    if (wr_i && w_sel_hram) begin
      r_hram[addr_i[6:0]] <= wdata_i;
    end
  end
`endif

  always_comb begin
    rdata_o = UNMAPPED_READ;
    hit_o   = 1'b0;
    case (addr_i)
      C_ADDR_DIV:  begin rdata_o = r_div[DIV_WIDTH-1 -: 8];  hit_o = 1'b1; end
      C_ADDR_TIMA: begin rdata_o = r_tima;                   hit_o = 1'b1; end
      C_ADDR_TMA:  begin rdata_o = r_tma;                    hit_o = 1'b1; end
      C_ADDR_TAC:  begin rdata_o = {5'b11111, r_tac};        hit_o = 1'b1; end
      C_ADDR_IF:   begin rdata_o = {3'b111, r_if};           hit_o = 1'b1; end
      C_ADDR_IE:   begin rdata_o = r_ie;                     hit_o = 1'b1; end
      default:     begin end
    endcase
`ifdef GB_IO_HRAM_EN
    if (w_sel_hram) begin
      rdata_o = r_hram[addr_i[6:0]];
      hit_o   = 1'b1;
    end
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_gb_io_responder.sv
// ============================================================================
// Module  : tb_gb_io_responder
// Purpose : Directed self-checking bench for gb_io_responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gb_io_responder;

  logic        clk;
  logic        reset;
  logic [15:0] addr_i;
  logic [7:0]  wdata_i;
  logic        wr_i;
  logic [7:0]  rdata_o;
  logic        hit_o;
  logic [4:0]  irq_i;
  logic        clear_interrupt_flag;
  logic [7:0]  reg_IF;
  logic [7:0]  reg_IE;

  int total = 0;
  int bad   = 0;
  int n;

  gb_io_responder #(
    .DIV_WIDTH     (16),
    .UNMAPPED_READ (8'hFF)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .addr_i               (addr_i),
    .wdata_i              (wdata_i),
    .wr_i                 (wr_i),
    .rdata_o              (rdata_o),
    .hit_o                (hit_o),
    .irq_i                (irq_i),
    .clear_interrupt_flag (clear_interrupt_flag),
    .reg_IF               (reg_IF),
    .reg_IE               (reg_IE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr_i  = a;
    wdata_i = d;
    wr_i    = 1'b1;
    @(negedge clk);
    wr_i    = 1'b0;
    addr_i  = 16'h0000;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp, input logic exp_hit);
    @(negedge clk);
    addr_i = a;
    #1;
    chk(tag, {8'h00, rdata_o}, {8'h00, exp});
    chk({tag, "_hit"}, {15'd0, hit_o}, {15'd0, exp_hit});
  endtask

  task automatic pulse_irq(input logic [4:0] v);
    @(negedge clk);
    irq_i = v;
    @(negedge clk);
    irq_i = 5'd0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_interrupt_flag = 1'b1;
    @(negedge clk);
    clear_interrupt_flag = 1'b0;
  endtask

  initial begin
    reset = 1'b0; addr_i = 16'h0000; wdata_i = 8'h00; wr_i = 1'b0;
    irq_i = 5'd0; clear_interrupt_flag = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_IF", {8'h00, reg_IF}, 16'h00E0);
    chk("rst_IE", {8'h00, reg_IE}, 16'h0000);
    reset = 1'b1;

    rd("rd_IF",   16'hFF0F, 8'hE0, 1'b1);
    rd("rd_IE",   16'hFFFF, 8'h00, 1'b1);
    rd("rd_TAC",  16'hFF07, 8'hF8, 1'b1);
    rd("rd_unm",  16'h1234, 8'hFF, 1'b0);
    rd("rd_TIMA", 16'hFF05, 8'h00, 1'b1);
    rd("rd_TMA",  16'hFF06, 8'h00, 1'b1);

    // TAC keeps only its low three bits
    bus_write(16'hFF07, 8'hF3);
    rd("tac_mask", 16'hFF07, 8'hFB, 1'b1);

    // Timer reload on overflow
    bus_write(16'hFF06, 8'hF0);
    bus_write(16'hFF05, 8'hFE);
    bus_write(16'hFF07, 8'h05);
    rd("tma_wr", 16'hFF06, 8'hF0, 1'b1);
    addr_i = 16'hFF05;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (rdata_o == 8'hFF) break;
    end
    chk("tima_ff", {8'h00, rdata_o}, 16'h00FF);
    chk("if_before_ovf", {8'h00, reg_IF}, 16'h00E0);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk); #1;
      n = i;
      if (rdata_o != 8'hFF) break;
    end
    chk("tick_period", n[15:0], 16'd16);
    chk("tima_reload", {8'h00, rdata_o}, 16'h00F0);
    chk("if_ovf", {8'h00, reg_IF}, 16'h00E4);
    bus_write(16'hFF07, 8'h00);
    bus_write(16'hFF0F, 8'h00);
    chk("if_cleared", {8'h00, reg_IF}, 16'h00E0);

    // Interrupt set / acknowledge
    bus_write(16'hFFFF, 8'h05);
    chk("ie_wr", {8'h00, reg_IE}, 16'h0005);
    pulse_irq(5'b00001);
    chk("if_vblank", {8'h00, reg_IF}, 16'h00E1);
    bus_write(16'hFF06, 8'h00);
    bus_write(16'hFF05, 8'hFF);
    bus_write(16'hFF07, 8'h05);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (reg_IF[2]) break;
    end
    chk("if_both", {8'h00, reg_IF}, 16'h00E5);
    rd("tima_wrap0", 16'hFF05, 8'h00, 1'b1);
    bus_write(16'hFF07, 8'h00);
    pulse_clear();
    chk("ack1", {8'h00, reg_IF}, 16'h00E4);
    pulse_clear();
    chk("ack2", {8'h00, reg_IF}, 16'h00E0);
    pulse_clear();
    chk("ack3", {8'h00, reg_IF}, 16'h00E0);

    // Hardware set beats acknowledge on the same bit
    bus_write(16'hFF0F, 8'h01);
    bus_write(16'hFFFF, 8'h01);
    chk("if_wr01", {8'h00, reg_IF}, 16'h00E1);
    @(negedge clk);
    irq_i = 5'b00001; clear_interrupt_flag = 1'b1;
    @(negedge clk);
    irq_i = 5'd0; clear_interrupt_flag = 1'b0;
    chk("set_vs_ack", {8'h00, reg_IF}, 16'h00E1);
    pulse_clear();
    chk("ack_alone", {8'h00, reg_IF}, 16'h00E0);

    // Hardware set beats a CPU write of zero; CPU write masks to [4:0]
    @(negedge clk);
    addr_i = 16'hFF0F; wdata_i = 8'h00; wr_i = 1'b1; irq_i = 5'b01000;
    @(negedge clk);
    wr_i = 1'b0; irq_i = 5'd0;
    chk("set_vs_wr", {8'h00, reg_IF}, 16'h00E8);
    bus_write(16'hFF0F, 8'hE2);
    chk("if_wr_mask", {8'h00, reg_IF}, 16'h00E2);
    bus_write(16'hFF0F, 8'h00);

    // DIV reset and the falling-edge glitch tick
    repeat (16'h300) @(negedge clk);
    bus_write(16'hFF04, 8'h5A);
    rd("div_clr", 16'hFF04, 8'h00, 1'b1);
    bus_write(16'hFF05, 8'h10);
    bus_write(16'hFF07, 8'h04);
    addr_i = 16'hFF04;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk); #1;
      if (rdata_o[1]) break;
    end
    chk("div9_high", {15'd0, rdata_o[1]}, 16'd1);
    rd("tima_pre_glitch", 16'hFF05, 8'h10, 1'b1);
    bus_write(16'hFF04, 8'h00);
    rd("div_clr2", 16'hFF04, 8'h00, 1'b1);
    rd("tima_glitch", 16'hFF05, 8'h11, 1'b1);

    // Disabling the timer while the selected bit is high must not tick
    addr_i = 16'hFF04;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk); #1;
      if (rdata_o[1]) break;
    end
    chk("div9_high2", {15'd0, rdata_o[1]}, 16'd1);
    bus_write(16'hFF07, 8'h00);
    repeat (600) @(negedge clk);
    rd("tima_no_tick", 16'hFF05, 8'h11, 1'b1);

`ifdef GB_IO_HRAM_EN
    bus_write(16'hFF80, 8'hA5);
    bus_write(16'hFFFE, 8'h5A);
    rd("hram_lo", 16'hFF80, 8'hA5, 1'b1);
    rd("hram_hi", 16'hFFFE, 8'h5A, 1'b1);
    rd("ie_vs_hram", 16'hFFFF, 8'h01, 1'b1);
`else
    bus_write(16'hFF80, 8'hA5);
    rd("no_hram_lo", 16'hFF80, 8'hFF, 1'b0);
    rd("no_hram_hi", 16'hFFFE, 8'hFF, 1'b0);
    rd("ie_kept", 16'hFFFF, 8'h01, 1'b1);
`endif

    // Reset in the middle of a write aborts it
    @(negedge clk);
    addr_i = 16'hFFFF; wdata_i = 8'hAA; wr_i = 1'b1; reset = 1'b0;
    #1;
    chk("midrst_IE", {8'h00, reg_IE}, 16'h0000);
    chk("midrst_IF", {8'h00, reg_IF}, 16'h00E0);
    @(negedge clk);
    chk("midrst_IE2", {8'h00, reg_IE}, 16'h0000);
    wr_i = 1'b0; reset = 1'b1;
    rd("post_rst_IE", 16'hFFFF, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
